// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32 core with memory handshake and timeout watchdog.
// Define MCCTRL_INSTRET_EN to build the retired-instruction counter; otherwise instret is tied to 0.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [6:0]           opcode,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 i_or_d,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_c,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 halted,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [INSTRET_W-1:0] instret
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MADDR,
        S_MRD, S_MWB, S_MWR, S_BRANCH, S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d, bus_err_q, bus_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_write_c = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                case (opcode)
                    7'b0110011:             state_d = S_EXEC;
                    7'b0000011, 7'b0100011: state_d = S_MADDR;
                    7'b1100011:             state_d = S_BRANCH;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // opcode bit 5 separates store (0100011) from load (0000011)
                state_d   = opcode[5] ? S_MWR : S_MRD;
            end
            S_MRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                state_d = mem_ready ? S_MWB : S_MRD;
            end
            S_MWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                state_d = mem_ready ? S_FETCH : S_MWR;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_write_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT:   halted = 1'b1;
            default:  state_d = S_HALT;
        endcase
        // A ready in the limit cycle completes the access; only a miss there trips the watchdog.
        if (mem_req && !mem_ready) begin
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d   = S_HALT;
                bus_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

`ifdef MCCTRL_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q;
    logic                 retire;

    assign retire = (state_q == S_ALUWB) || (state_q == S_MWB) || (state_q == S_BRANCH) ||
                    ((state_q == S_MWR) && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) instret_q <= '0;
        else if (retire) instret_q <= instret_q + 1'b1;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif
endmodule
